dbus_wb_bridge: RTL and testbench
=================================

// Module: dbus_wb_bridge
// PURPOSE
//  Data-bus slave-side adapter: takes the CPU memory-stage data bus (addr/be/wr/rd/busy/ack) and
//  runs each access as a single Wishbone B4 classic cycle towards the SoC data interconnect.
//  Captures the request, drives busy while the cycle is open and returns read data with a one-cycle ack.
//  Adds a bus-timeout watchdog so that a silent slave cannot hang the core.
// PARAMETERS
//  p_timeout      255           cycles allowed in BUS state before forced termination; 0 = watchdog disabled
//  p_err_rd_value 32'hDEADBEEF  read data returned on wb_err_i or timeout
// PORTS
//  i_clk          in   1   global clock, rising edge
//  i_rstn         in   1   synchronous reset, active low
//  dbus_addr      in   32  word address from CPU (bits [1:0] are 0)
//  dbus_be        in   4   byte enables
//  dbus_wr_en     in   1   write request
//  dbus_wr_data   in   32  aligned write data
//  dbus_rd_en     in   1   read request
//  dbus_rd_data   out  32  read data, valid while dbus_ack=1
//  dbus_busy      out  1   bridge cannot accept a request
//  dbus_ack       out  1   one-cycle transfer completion
//  wb_adr_o       out  32  Wishbone address
//  wb_dat_o       out  32  Wishbone write data
//  wb_sel_o       out  4   Wishbone byte select
//  wb_we_o        out  1   Wishbone write enable
//  wb_cyc_o       out  1   Wishbone cycle
//  wb_stb_o       out  1   Wishbone strobe
//  wb_dat_i       in   32  Wishbone read data
//  wb_ack_i       in   1   Wishbone acknowledge
//  wb_err_i       in   1   Wishbone error
//  o_bus_err      out  1   one-cycle pulse with dbus_ack when the access ended on error/timeout
// BEHAVIOUR
//  Interface: one clock (i_clk); reset is synchronous and active-low (i_rstn).
//  Reset: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-cycle drops wb_cyc_o/wb_stb_o
//   at that edge, and no ack is ever issued for the aborted access.
//  FSM IDLE -> BUS -> DONE -> IDLE.
//  IDLE: dbus_busy=0. If wr_en|rd_en at a clock edge: latch addr/be/wr_data into wb_*_o, set wb_we_o=wr_en,
//   set cyc=stb=1, go to BUS. wr_en and rd_en both high: the access is a write and the read is dropped.
//   With no request, the wb_*_o data outputs hold their last value and cyc/stb=0.
//  BUS: dbus_busy=1; cyc/stb held; all wb outputs stable. Counter increments every BUS cycle.
//   wb_ack_i=1: cyc/stb<=0, rd_data<=wb_dat_i if read, go to DONE.
//   wb_err_i=1 (priority over ack when both high), or counter==p_timeout-1 with p_timeout!=0:
//   cyc/stb<=0, rd_data<=p_err_rd_value if read, err flag<=1, go to DONE.
//  DONE: dbus_ack=1, o_bus_err=err flag, dbus_busy=1, go to IDLE; counter and err flag cleared.
//   New requests are ignored in DONE and BUS (the requester holds its request until ack).
//  dbus_rd_data is registered and holds until the next read completion; a write does not alter it.
//  Latency: request at edge N -> cyc/stb high in cycle N+1; ack from a zero-wait slave at edge N+1
//   -> dbus_ack high in cycle N+2. Each wait state adds one cycle. Throughput: one access every 3 cycles min.
//  Timeout: with p_timeout=T, the cycle is forced closed after exactly T cycles in BUS with no ack/err.
// TESTING
//  T1 read, 0-wait slave, addr 0x100, wb_dat_i=0x11223344 -> cyc 1 cycle, dbus_ack 2 cycles after req, rd_data 0x11223344
//  T2 write 0xCAFEF00D be=4'b0011 addr 0x204, 3 wait states -> wb_sel_o=0011, we=1 for 4 cycles, ack 5 cycles after req, rd_data unchanged
//  T3 read, slave silent, p_timeout=8 -> cyc drops after 8 cycles, ack+o_bus_err pulse, rd_data=0xDEADBEEF
//  T4 read with wb_err_i and wb_ack_i high together -> o_bus_err=1, rd_data=0xDEADBEEF, busy low next cycle
//  T5 wr_en=rd_en=1 -> single write cycle (we=1), exactly one ack, no read issued
//  T6 i_rstn low during BUS -> cyc/stb/busy 0 next edge; late wb_ack_i after reset produces no dbus_ack

Source files
------------

// File: rtl/dbus_wb_bridge_if.sv
// rtl/dbus_wb_bridge_if.sv - CPU data-bus and Wishbone signal bundle for dbus_wb_bridge
interface dbus_wb_bridge_if;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic        dbus_wr_en;
    logic [31:0] dbus_wr_data;
    logic        dbus_rd_en;
    logic [31:0] dbus_rd_data;
    logic        dbus_busy;
    logic        dbus_ack;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        o_bus_err;

    modport slave (
        input  dbus_addr, dbus_be, dbus_wr_en, dbus_wr_data, dbus_rd_en,
        output dbus_rd_data, dbus_busy, dbus_ack,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output o_bus_err
    );

    modport master (
        output dbus_addr, dbus_be, dbus_wr_en, dbus_wr_data, dbus_rd_en,
        input  dbus_rd_data, dbus_busy, dbus_ack,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  o_bus_err
    );
endinterface

// File: rtl/dbus_wb_bridge.sv
// rtl/dbus_wb_bridge.sv - CPU data bus to Wishbone B4 classic single-cycle bridge with timeout watchdog
module dbus_wb_bridge #(
    parameter int unsigned p_timeout      = 255,
    parameter logic [31:0] p_err_rd_value = 32'hDEADBEEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    dbus_wb_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] c_limit = 16'(p_timeout - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic req;
    logic timeout_hit;

    assign req         = bus.dbus_wr_en | bus.dbus_rd_en;
    assign timeout_hit = (p_timeout != 0) && (cnt_q == c_limit);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Write wins over a simultaneous read: we_d takes wr_en directly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d   = bus.dbus_addr;
                    dat_d   = bus.dbus_wr_data;
                    sel_d   = bus.dbus_be;
                    we_d    = bus.dbus_wr_en;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.wb_err_i || (!bus.wb_ack_i && timeout_hit)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!we_q) rd_data_d = p_err_rd_value;
                end else if (bus.wb_ack_i) begin
                    state_d = ST_DONE;
                    if (!we_q) rd_data_d = bus.wb_dat_i;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.dbus_busy    = (state_q != ST_IDLE);
        bus.dbus_ack     = (state_q == ST_DONE);
        bus.o_bus_err    = (state_q == ST_DONE) && err_q;
        bus.wb_cyc_o     = (state_q == ST_BUS);
        bus.wb_stb_o     = (state_q == ST_BUS);
        bus.wb_adr_o     = adr_q;
        bus.wb_dat_o     = dat_q;
        bus.wb_sel_o     = sel_q;
        bus.wb_we_o      = we_q;
        bus.dbus_rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// tb/tb_dbus_wb_bridge.sv - self-checking bench for dbus_wb_bridge
module tb_dbus_wb_bridge;

    localparam int unsigned c_timeout = 8;

    typedef struct {
        logic [31:0] rd_data;
        logic        err;
    } exp_t;

    typedef enum int {
        SL_ACK    = 0,
        SL_ERR    = 1,
        SL_BOTH   = 2,
        SL_SILENT = 3,
        SL_MANUAL = 4
    } slave_mode_t;

    logic clk;
    logic rstn;
    int   compared;
    int   mismatched;
    exp_t sb[$];
    logic [31:0] model_rd;

    slave_mode_t sl_mode;
    int          sl_wait;
    int          sl_cnt;

    dbus_wb_bridge_if bus();

    dbus_wb_bridge #(
        .p_timeout      (c_timeout),
        .p_err_rd_value (32'hDEADBEEF)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sl_mode != SL_MANUAL) begin
            if (bus.wb_cyc_o && bus.wb_stb_o) begin
                if (sl_cnt == sl_wait) begin
                    bus.wb_ack_i = (sl_mode == SL_ACK) || (sl_mode == SL_BOTH);
                    bus.wb_err_i = (sl_mode == SL_ERR) || (sl_mode == SL_BOTH);
                end
                sl_cnt = sl_cnt + 1;
            end else begin
                bus.wb_ack_i = 1'b0;
                bus.wb_err_i = 1'b0;
                sl_cnt       = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string name, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input slave_mode_t mode,
                          input int wait_st, input logic [31:0] sdata,
                          input int exp_lat, input int exp_cyc, input bit exp_err);
        exp_t e;
        exp_t got_e;
        int   lat;
        int   cyc_cnt;
        int   we_cnt;
        bit   got;
        bit   bad_bus;
        bit   is_write;
        is_write = wr;
        if (!is_write) model_rd = exp_err ? 32'hDEADBEEF : sdata;
        e.rd_data = model_rd;
        e.err     = exp_err;
        sb.push_back(e);

        @(negedge clk);
        sl_mode           = mode;
        sl_wait           = wait_st;
        bus.wb_dat_i      = sdata;
        bus.dbus_addr     = addr;
        bus.dbus_be       = be;
        bus.dbus_wr_data  = wdata;
        bus.dbus_wr_en    = wr;
        bus.dbus_rd_en    = rd;

        lat = 0; cyc_cnt = 0; we_cnt = 0; got = 0; bad_bus = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.wb_cyc_o) begin
                cyc_cnt++;
                if (bus.wb_we_o) we_cnt++;
                if (bus.wb_adr_o !== addr || bus.wb_sel_o !== be || !bus.wb_stb_o || !bus.dbus_busy) bad_bus = 1;
                if (is_write && bus.wb_dat_o !== wdata) bad_bus = 1;
            end
            if (bus.dbus_ack) begin
                got = 1;
                got_e = sb.pop_front();
                chk({name, " rd_data"}, bus.dbus_rd_data, got_e.rd_data);
                chk({name, " bus_err"}, 32'(bus.o_bus_err), 32'(got_e.err));
                chk({name, " busy_at_ack"}, 32'(bus.dbus_busy), 32'd1);
            end
        end
        bus.dbus_wr_en = 1'b0;
        bus.dbus_rd_en = 1'b0;

        chk({name, " ack_seen"}, 32'(got), 32'd1);
        chk({name, " ack_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
        chk({name, " we_cycles"}, 32'(we_cnt), is_write ? 32'(exp_cyc) : 32'd0);
        chk({name, " wb_outputs"}, 32'(bad_bus), 32'd0);

        @(posedge clk);
        #1;
        chk({name, " ack_one_cycle"}, 32'(bus.dbus_ack), 32'd0);
        chk({name, " busy_after"}, 32'(bus.dbus_busy), 32'd0);
        chk({name, " no_second_cyc"}, 32'(bus.wb_cyc_o), 32'd0);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        model_rd     = 32'h0;
        sl_mode      = SL_ACK;
        sl_wait      = 0;
        sl_cnt       = 0;
        rstn         = 1'b0;
        bus.dbus_addr    = '0;
        bus.dbus_be      = '0;
        bus.dbus_wr_en   = 1'b0;
        bus.dbus_wr_data = '0;
        bus.dbus_rd_en   = 1'b0;
        bus.wb_dat_i     = '0;
        bus.wb_ack_i     = 1'b0;
        bus.wb_err_i     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.dbus_busy), 32'd0);
        chk("reset ack", 32'(bus.dbus_ack), 32'd0);
        chk("reset cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("reset stb", 32'(bus.wb_stb_o), 32'd0);
        chk("reset we", 32'(bus.wb_we_o), 32'd0);
        chk("reset rd_data", bus.dbus_rd_data, 32'h0);
        chk("reset bus_err", 32'(bus.o_bus_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        access("t1_read", 1'b0, 1'b1, 32'h100, 4'hF, 32'h0, SL_ACK, 0, 32'h11223344, 2, 1, 1'b0);
        access("t2_write", 1'b1, 1'b0, 32'h204, 4'b0011, 32'hCAFEF00D, SL_ACK, 3, 32'h55555555, 5, 4, 1'b0);
        chk("t2 rd_data_kept", bus.dbus_rd_data, 32'h11223344);
        access("t3_timeout", 1'b0, 1'b1, 32'h300, 4'hF, 32'h0, SL_SILENT, 0, 32'h12345678, c_timeout + 1, c_timeout, 1'b1);
        access("t1b_read", 1'b0, 1'b1, 32'h104, 4'hF, 32'h0, SL_ACK, 2, 32'hA5A5_0F0F, 4, 3, 1'b0);
        access("t4_err_ack", 1'b0, 1'b1, 32'h400, 4'hF, 32'h0, SL_BOTH, 0, 32'h99999999, 2, 1, 1'b1);
        access("t5_wr_rd", 1'b1, 1'b1, 32'h500, 4'b1100, 32'h0BADF00D, SL_ACK, 0, 32'h77777777, 2, 1, 1'b0);
        chk("t5 rd_data_kept", bus.dbus_rd_data, 32'hDEADBEEF);
        access("t4b_err_wr", 1'b1, 1'b0, 32'h600, 4'b0001, 32'h000000AA, SL_ERR, 1, 32'h0, 3, 2, 1'b1);

        // T6: reset in the middle of an open cycle, then a stale slave ack.
        @(negedge clk);
        sl_mode        = SL_SILENT;
        bus.dbus_addr  = 32'h700;
        bus.dbus_be    = 4'hF;
        bus.dbus_rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6 cyc_open", 32'(bus.wb_cyc_o), 32'd1);
        @(negedge clk);
        rstn           = 1'b0;
        bus.dbus_rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 cyc_dropped", 32'(bus.wb_cyc_o), 32'd0);
        chk("t6 stb_dropped", 32'(bus.wb_stb_o), 32'd0);
        chk("t6 busy_dropped", 32'(bus.dbus_busy), 32'd0);
        chk("t6 rd_data_cleared", bus.dbus_rd_data, 32'h0);
        @(negedge clk);
        rstn         = 1'b1;
        sl_mode      = SL_MANUAL;
        bus.wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6 no_ack_%0d", i), 32'(bus.dbus_ack), 32'd0);
            if (i == 1) bus.wb_ack_i = 1'b0;
        end
        chk("t6 scoreboard_empty", 32'(sb.size()), 32'd0);
        model_rd = 32'h0;
        sl_mode  = SL_ACK;

        access("t7_after_rst", 1'b0, 1'b1, 32'h800, 4'hF, 32'h0, SL_ACK, 0, 32'h600DF00D, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
